// File: rtl/button_gesture_decoder.sv
// Turns a debounced button level into SHORT / LONG / DOUBLE gesture events
// and queues them for a consumer through a valid/ready FIFO.
module button_gesture_decoder #(
    parameter int LONG_CYCLES = 50_000_000,
    parameter int DTAP_CYCLES = 25_000_000,
    parameter int CNT_W       = 26,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_level,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [1:0] evt_code,
    output logic       overflow,
    output logic [7:0] drop_cnt,
    output logic       busy
);
    localparam int              AW         = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] LONG_N     = CNT_W'(LONG_CYCLES);
    localparam logic [CNT_W-1:0] DTAP_N     = CNT_W'(DTAP_CYCLES);
    localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
    localparam logic [1:0]      CODE_SHORT = 2'b01;
    localparam logic [1:0]      CODE_LONG  = 2'b10;
    localparam logic [1:0]      CODE_DBL   = 2'b11;

    typedef enum logic [1:0] {IDLE, PRESS1, GAP, HOLD} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] timer, timer_nxt, timer_inc;
    logic             btn_prev, rise;
    logic             push;
    logic [1:0]       push_code;

    assign rise      = btn_level & ~btn_prev;
    assign timer_inc = timer + ONE;
    assign busy      = (state != IDLE);

    // btn_prev resets high so a button held through reset is not seen as a press
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            timer    <= '0;
            btn_prev <= 1'b1;
        end else begin
            state    <= state_nxt;
            timer    <= timer_nxt;
            btn_prev <= btn_level;
        end
    end

    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        push      = 1'b0;
        push_code = CODE_SHORT;
        case (state)
            IDLE: begin
                if (rise) begin
                    state_nxt = PRESS1;
                    timer_nxt = ONE;
                end
            end
            PRESS1: begin
                if (btn_level) begin
                    if (timer_inc == LONG_N) begin
                        push      = 1'b1;
                        push_code = CODE_LONG;
                        state_nxt = HOLD;
                        timer_nxt = '0;
                    end else begin
                        timer_nxt = timer_inc;
                    end
                end else begin
                    state_nxt = GAP;
                    timer_nxt = ONE;
                end
            end
            GAP: begin
                // a second rise beats an expiring gap on the same sample
                if (rise) begin
                    push      = 1'b1;
                    push_code = CODE_DBL;
                    state_nxt = HOLD;
                    timer_nxt = '0;
                end else if (timer_inc == DTAP_N) begin
                    push      = 1'b1;
                    push_code = CODE_SHORT;
                    state_nxt = IDLE;
                    timer_nxt = '0;
                end else begin
                    timer_nxt = timer_inc;
                end
            end
            HOLD: begin
                if (!btn_level) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    logic [1:0]  mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        empty, full, pop, do_push;

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop       = ~empty & evt_ready;
    assign do_push   = push & (~full | pop);
    assign overflow  = push & full & ~pop;
    assign evt_valid = ~empty;
    assign evt_code  = empty ? 2'b00 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            drop_cnt <= 8'd0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)     rd_ptr <= rd_ptr + (AW+1)'(1);
            if (overflow && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
        end
    end

    // queue storage holds data only; validity comes from the pointers
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_code;
    end
endmodule

// File: tb/tb_button_gesture_decoder.sv
// Self-checking bench for button_gesture_decoder: directed vector table,
// hand-written FIFO/reset corner sequences and randomized runs against a gesture model.
module tb_button_gesture_decoder;
    localparam int LONG  = 8;
    localparam int DTAP  = 6;
    localparam int DEPTH = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_level = 1'b0;
    logic       evt_ready = 1'b0;
    logic       evt_valid;
    logic [1:0] evt_code;
    logic       overflow;
    logic [7:0] drop_cnt;
    logic       busy;

    int checks = 0;
    int failures = 0;

    button_gesture_decoder #(
        .LONG_CYCLES(LONG),
        .DTAP_CYCLES(DTAP),
        .CNT_W(4),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .btn_level(btn_level),
        .evt_valid(evt_valid),
        .evt_ready(evt_ready),
        .evt_code(evt_code),
        .overflow(overflow),
        .drop_cnt(drop_cnt),
        .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s act=%0d exp=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // Gesture model: counts the high run of the first press and the low run after it.
    int m_q[$];
    int m_drops;
    bit m_prev, m_press, m_hold;
    int m_hi, m_lo;

    task automatic model_reset();
        m_q.delete();
        m_drops = 0;
        m_prev  = 1'b1;
        m_press = 1'b0;
        m_hold  = 1'b0;
        m_hi    = 0;
        m_lo    = 0;
    endtask

    task automatic model_step(input bit b, output int ev);
        bit rise;
        rise = b && !m_prev;
        ev = 0;
        if (m_hold) begin
            if (!b) m_hold = 1'b0;
        end else if (m_press && m_lo == 0) begin
            if (b) begin
                m_hi++;
                if (m_hi == LONG) begin ev = 2; m_press = 1'b0; m_hold = 1'b1; end
            end else begin
                m_lo = 1;
            end
        end else if (m_press) begin
            if (b) begin
                ev = 3; m_press = 1'b0; m_hold = 1'b1;
            end else begin
                m_lo++;
                if (m_lo == DTAP) begin ev = 1; m_press = 1'b0; end
            end
        end else if (rise) begin
            m_press = 1'b1; m_hi = 1; m_lo = 0;
        end
        m_prev = b;
    endtask

    int s_valid, s_code, s_ovf, s_drop, s_busy;

    // Entered just after a rising edge; inputs are held for one cycle, outputs sampled at negedge.
    task automatic run_cycle(input bit b, input bit r);
        int ev, e_valid, e_code, e_busy, e_drop, e_ovf;
        bit pop, full_b;
        btn_level = b;
        evt_ready = r;
        @(negedge clk);
        s_valid = evt_valid; s_code = evt_code; s_ovf = overflow;
        s_drop = drop_cnt; s_busy = busy;
        e_valid = (m_q.size() != 0) ? 1 : 0;
        e_code  = e_valid ? m_q[0] : 0;
        e_busy  = (m_press || m_hold) ? 1 : 0;
        e_drop  = m_drops;
        model_step(b, ev);
        full_b = (m_q.size() == DEPTH);
        pop    = (e_valid != 0) && r;
        e_ovf  = (ev != 0 && full_b && !pop) ? 1 : 0;
        check("m_valid", s_valid, e_valid);
        check("m_code", s_code, e_code);
        check("m_overflow", s_ovf, e_ovf);
        check("m_drop_cnt", s_drop, e_drop);
        check("m_busy", s_busy, e_busy);
        if (pop) void'(m_q.pop_front());
        if (ev != 0) begin
            if (!full_b || pop) m_q.push_back(ev);
            else if (m_drops < 255) m_drops++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, evt_valid, 0);
        check({tag, "_code"}, evt_code, 0);
        check({tag, "_overflow"}, overflow, 0);
        check({tag, "_drop_cnt"}, drop_cnt, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    task automatic do_reset(input bit b);
        btn_level = b;
        evt_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #13;
        check_reset_outputs("rst_mid");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit b;
        bit r;
        int v;
        int c;
        int o;
        int d;
        int bz;
    } vec_t;

    vec_t vecs[$];

    task automatic addn(input int n, input bit b, input bit r, input int v, input int c,
                        input int o, input int d, input int bz);
        vec_t e;
        e.b = b; e.r = r; e.v = v; e.c = c; e.o = o; e.d = d; e.bz = bz;
        for (int i = 0; i < n; i++) vecs.push_back(e);
    endtask

    initial begin
        int ovf_seen;
        bit lvl;
        int len, bias;
        bit r;

        // SHORT: 3 high, 6 low; valid for exactly one cycle
        addn(1, 0, 1, 0, 0, 0, 0, 0);
        addn(1, 1, 1, 0, 0, 0, 0, 0);
        addn(2, 1, 1, 0, 0, 0, 0, 1);
        addn(6, 0, 1, 0, 0, 0, 0, 1);
        addn(1, 0, 1, 1, 1, 0, 0, 0);
        addn(1, 0, 1, 0, 0, 0, 0, 0);
        // LONG on 8th high sample, nothing more while held or on release
        addn(1, 1, 1, 0, 0, 0, 0, 0);
        addn(7, 1, 1, 0, 0, 0, 0, 1);
        addn(1, 1, 1, 1, 2, 0, 0, 1);
        addn(1, 1, 1, 0, 0, 0, 0, 1);
        addn(1, 0, 1, 0, 0, 0, 0, 1);
        addn(1, 0, 1, 0, 0, 0, 0, 0);
        // DOUBLE after a 3-sample gap
        addn(1, 1, 1, 0, 0, 0, 0, 0);
        addn(1, 1, 1, 0, 0, 0, 0, 1);
        addn(3, 0, 1, 0, 0, 0, 0, 1);
        addn(1, 1, 1, 0, 0, 0, 0, 1);
        addn(1, 1, 1, 1, 3, 0, 0, 1);
        addn(1, 0, 1, 0, 0, 0, 0, 1);
        addn(1, 0, 1, 0, 0, 0, 0, 0);
        // exactly 6 low samples -> SHORT; following press is a fresh gesture
        addn(1, 1, 1, 0, 0, 0, 0, 0);
        addn(1, 1, 1, 0, 0, 0, 0, 1);
        addn(6, 0, 1, 0, 0, 0, 0, 1);
        addn(1, 1, 1, 1, 1, 0, 0, 0);
        addn(6, 0, 1, 0, 0, 0, 0, 1);
        addn(1, 0, 1, 1, 1, 0, 0, 0);
        addn(1, 0, 1, 0, 0, 0, 0, 0);
        // rise on the sample where the gap would expire -> DOUBLE
        addn(1, 1, 1, 0, 0, 0, 0, 0);
        addn(5, 0, 1, 0, 0, 0, 0, 1);
        addn(1, 1, 1, 0, 0, 0, 0, 1);
        addn(1, 1, 1, 1, 3, 0, 0, 1);
        addn(1, 0, 1, 0, 0, 0, 0, 1);
        addn(1, 0, 1, 0, 0, 0, 0, 0);

        model_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst_init");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            run_cycle(vecs[i].b, vecs[i].r);
            check($sformatf("vec%0d_valid", i), s_valid, vecs[i].v);
            check($sformatf("vec%0d_code", i), s_code, vecs[i].c);
            check($sformatf("vec%0d_overflow", i), s_ovf, vecs[i].o);
            check($sformatf("vec%0d_drop_cnt", i), s_drop, vecs[i].d);
            check($sformatf("vec%0d_busy", i), s_busy, vecs[i].bz);
        end

        // three SHORTs with no consumer: third one is dropped
        ovf_seen = 0;
        for (int g = 0; g < 3; g++) begin
            run_cycle(1, 0); ovf_seen += s_ovf;
            for (int k = 0; k < DTAP; k++) begin
                run_cycle(0, 0); ovf_seen += s_ovf;
            end
        end
        run_cycle(0, 0); ovf_seen += s_ovf;
        check("full_ovf_pulses", ovf_seen, 1);
        check("full_drop_cnt", s_drop, 1);
        check("full_valid", s_valid, 1);
        run_cycle(0, 1);
        check("drain0_valid", s_valid, 1);
        check("drain0_code", s_code, 1);
        run_cycle(0, 1);
        check("drain1_valid", s_valid, 1);
        check("drain1_code", s_code, 1);
        run_cycle(0, 1);
        check("drain2_valid", s_valid, 0);

        // full FIFO with pop on the push cycle: no drop
        for (int g = 0; g < 2; g++) begin
            run_cycle(1, 0);
            for (int k = 0; k < DTAP; k++) run_cycle(0, 0);
        end
        run_cycle(1, 0);
        for (int k = 0; k < DTAP - 1; k++) run_cycle(0, 0);
        run_cycle(0, 1);
        check("pushpop_overflow", s_ovf, 0);
        run_cycle(0, 0);
        check("pushpop_drop_cnt", s_drop, 1);
        check("pushpop_valid", s_valid, 1);
        repeat (3) run_cycle(0, 1);
        check("pushpop_drained", s_valid, 0);

        // reset mid-press with the button held through release
        run_cycle(1, 1);
        run_cycle(1, 1);
        run_cycle(1, 1);
        check("pre_rst_busy", s_busy, 1);
        do_reset(1);
        for (int k = 0; k < LONG + 4; k++) begin
            run_cycle(1, 1);
            check("held_busy", s_busy, 0);
            check("held_valid", s_valid, 0);
        end
        run_cycle(0, 1);
        check("released_busy", s_busy, 0);
        run_cycle(1, 1);
        run_cycle(1, 1);
        check("repress_busy", s_busy, 1);
        for (int k = 0; k < DTAP + 2; k++) run_cycle(0, 1);

        // randomized runs of alternating levels
        lvl = 1'b0;
        for (int n = 0; n < 300; n++) begin
            lvl  = ~lvl;
            len  = $urandom_range(1, 11);
            bias = $urandom_range(0, 1);
            for (int k = 0; k < len; k++) begin
                r = bias ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
                run_cycle(lvl, r);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
